replay_fifo: RTL and testbench
==============================

REPLAY_FIFO -- requirements
Module: replay_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 2, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, storage entries; power of two, >= 2.
REQ-003 SHALL have parameter AF_MARGIN, default 1, almost_full asserts when held >= DEPTH-AF_MARGIN.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of all pointers and flags.
REQ-007 SHALL have port rewind  input  1  move read pointer back to mark (replay).
REQ-008 SHALL have port commit  input  1  move mark to read pointer (release consumed entries).
REQ-009 SHALL have ports wr_en  input  1 and din  input  WIDTH  write request and data.
REQ-010 SHALL have ports rd_en  input  1, dout  output  WIDTH, dout_valid  output  1  read request, registered data, one-cycle valid pulse.
REQ-011 SHALL have ports empty, full, almost_full, overflow, underflow  output  1 each.
REQ-012 SHALL have ports unread_count, held_count  output  log2(DEPTH)+1 each.

Function
REQ-013 SHALL keep three pointers wr_ptr, rd_ptr, mark_ptr, each log2(DEPTH)+1 bits, MSB as wrap bit; addresses wrap modulo DEPTH.
REQ-014 SHALL define held_count = wr_ptr - mark_ptr and unread_count = wr_ptr - rd_ptr (modulo 2^(log2(DEPTH)+1)), driven combinationally from registered pointers.
REQ-015 SHALL assert full when held_count == DEPTH, empty when unread_count == 0, almost_full per REQ-003.
REQ-016 SHALL accept a write when wr_en && !full: store din at wr_ptr, wr_ptr+1; wr_en && full: no state change except overflow <= 1.
REQ-017 SHALL accept a read when rd_en && !empty && !rewind: dout <= entry[rd_ptr], rd_ptr+1, dout_valid = 1 next cycle; rd_en && empty: underflow <= 1, dout holds.
REQ-018 SHALL hold dout between accepted reads; dout_valid is 0 in any cycle not following an accepted read.
REQ-019 SHALL on rewind set rd_ptr <= mark_ptr; rd_en ignored that cycle (no underflow, no dout_valid); stored data untouched.
REQ-020 SHALL on commit (without rewind) set mark_ptr <= rd_ptr value after any same-cycle accepted read (i.e. includes that read).
REQ-021 SHALL ignore commit when rewind is asserted same cycle.
REQ-022 SHALL evaluate full/empty for write/read acceptance from pre-edge pointers; same-cycle commit does not free space for a same-cycle write.
REQ-023 SHALL process write concurrently with read, rewind or commit; simultaneous read and write on empty FIFO: write accepted, read rejected with underflow.
REQ-024 SHALL give clear priority over all other controls: all pointers <= 0, overflow/underflow <= 0, dout_valid <= 0, dout holds, storage untouched, wr_en/rd_en ignored.
REQ-025 SHALL keep overflow and underflow sticky until rst or clear.
REQ-026 SHALL never return data written after a read's sampling edge; read-after-write of same address in one cycle cannot occur since empty blocks it.

Reset
REQ-027 SHALL on rst asynchronously set wr_ptr, rd_ptr, mark_ptr, dout, dout_valid, overflow, underflow to 0; hence empty=1, full=0, almost_full=0 (DEPTH>AF_MARGIN), counts 0.
REQ-028 SHALL not reset storage array; contents undefined until written.
REQ-029 SHALL recover from rst asserted mid-operation on first clk edge after deassertion, with no residual flags or valid pulses.

Verification (WIDTH=2, DEPTH=4, AF_MARGIN=1)
REQ-030 SHALL test: write 1,2,3,0 -> full=1, almost_full=1, held_count=4; 5th write -> overflow=1, wr_ptr unchanged.
REQ-031 SHALL test: after REQ-030, read 4 -> dout 1,2,3,0 each with one-cycle dout_valid, empty=1, full=1 still (no commit); extra rd_en -> underflow=1.
REQ-032 SHALL test: read 2 entries, rewind -> unread_count=4; read 4 -> dout 1,2,3,0 replayed.
REQ-033 SHALL test: read 2, commit with concurrent rd_en -> held_count=1, full=0; write 4 words over wrap -> accepted until held_count=4, pointer wrap bit toggles.
REQ-034 SHALL test: rewind and commit same cycle -> rd_ptr=mark_ptr, mark unchanged; clear with wr_en/rd_en high -> counts 0, sticky flags 0, no write.
REQ-035 SHALL test: rst pulse asynchronous between edges mid-stream -> outputs zero immediately, empty=1; next write/read sequence correct.

Source files
------------

// File: rtl/replay_fifo.sv
// replay_fifo: single-clock FIFO with a replay mark.
//
// Entries stay resident after they are read until a commit moves the mark
// past them, so a rewind can replay everything read since the last commit.
// Space is therefore bounded by held_count (wr - mark), not unread_count.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   clear                    synchronous flush of pointers and sticky flags
//   rewind                   rd_ptr <= mark_ptr (replay)
//   commit                   mark_ptr <= rd_ptr (after same-cycle read)
//   wr_en, din               write request / data
//   rd_en, dout, dout_valid  read request / registered data / 1-cycle pulse
//   empty, full, almost_full occupancy flags
//   overflow, underflow      sticky error flags
//   unread_count, held_count wr-rd and wr-mark
module replay_fifo #(
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 256,
    parameter int AF_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       rewind,
    input  logic                       commit,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     unread_count,
    output logic [$clog2(DEPTH):0]     held_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] mark_ptr;
    logic [PW-1:0] rd_ptr_adv;
    logic          rd_accept;
    logic          wr_accept;

    assign held_count   = wr_ptr - mark_ptr;
    assign unread_count = wr_ptr - rd_ptr;
    assign full         = (held_count == PW'(DEPTH));
    assign empty        = (unread_count == '0);
    assign almost_full  = (held_count >= PW'(DEPTH - AF_MARGIN));

    // Acceptance uses pre-edge flags; a same-cycle commit cannot make room
    // for a same-cycle write.
    assign rd_accept  = rd_en && !empty && !rewind && !clear;
    assign wr_accept  = wr_en && !full && !clear;

    // Read pointer after any accepted read; commit captures this value so a
    // read in the commit cycle is released along with earlier ones.
    assign rd_ptr_adv = rd_accept ? rd_ptr + PW'(1) : rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mark_ptr   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mark_ptr   <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= rd_accept;
            if (rd_accept) begin
                dout <= mem[rd_ptr[AW-1:0]];
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            // A rewind cycle ignores rd_en entirely, including underflow.
            if (rd_en && empty && !rewind) begin
                underflow <= 1'b1;
            end
            rd_ptr <= rewind ? mark_ptr : rd_ptr_adv;
            if (commit && !rewind) begin
                mark_ptr <= rd_ptr_adv;
            end
        end
    end

    // Storage has no reset; only written locations are ever read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_replay_fifo.sv
module tb_replay_fifo;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int AFM   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             rewind;
    logic             commit;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic [2:0]       unread_count;
    logic [2:0]       held_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: unbounded entry counters and a plain array.
    int               m_wr, m_rd, m_mark;
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] m_dout;
    logic             m_dv, m_ovf, m_unf;

    replay_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk(clk), .rst(rst), .clear(clear), .rewind(rewind), .commit(commit),
        .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .dout_valid(dout_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
        .unread_count(unread_count), .held_count(held_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_wr = 0; m_rd = 0; m_mark = 0;
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic [WIDTH-1:0] d,
                                       input logic r, input logic rw,
                                       input logic cm, input logic cl);
        bit is_full, is_empty, rd_ok, wr_ok;
        int new_rd;
        if (cl) begin
            m_wr = 0; m_rd = 0; m_mark = 0;
            m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0;
            return;
        end
        is_full  = (m_wr - m_mark) == DEPTH;
        is_empty = (m_wr == m_rd);
        rd_ok    = r && !is_empty && !rw;
        wr_ok    = w && !is_full;
        if (w && is_full) m_ovf = 1'b1;
        if (r && is_empty && !rw) m_unf = 1'b1;
        m_dv = rd_ok;
        if (rd_ok) m_dout = m_mem[m_rd % DEPTH];
        new_rd = rw ? m_mark : m_rd + (rd_ok ? 1 : 0);
        if (cm && !rw) m_mark = new_rd;
        m_rd = new_rd;
        if (wr_ok) begin
            m_mem[m_wr % DEPTH] = d;
            m_wr++;
        end
    endfunction

    task automatic check_all();
        chk("dout_valid",   dout_valid,   m_dv);
        chk("dout",         dout,         m_dout);
        chk("empty",        empty,        (m_wr == m_rd) ? 1 : 0);
        chk("full",         full,         ((m_wr - m_mark) == DEPTH) ? 1 : 0);
        chk("almost_full",  almost_full,  ((m_wr - m_mark) >= DEPTH - AFM) ? 1 : 0);
        chk("overflow",     overflow,     m_ovf);
        chk("underflow",    underflow,    m_unf);
        chk("unread_count", unread_count, m_wr - m_rd);
        chk("held_count",   held_count,   m_wr - m_mark);
        chk("wr_wrap",      dut.wr_ptr[2], (m_wr / DEPTH) % 2);
    endtask

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic rw, input logic cm, input logic cl);
        wr_en = w; din = d; rd_en = r; rewind = rw; commit = cm; clear = cl;
        @(posedge clk);
        model_step(w, d, r, rw, cm, cl);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"},   dout,         0);
        chk({tag, "_dv"},     dout_valid,   0);
        chk({tag, "_empty"},  empty,        1);
        chk({tag, "_full"},   full,         0);
        chk({tag, "_af"},     almost_full,  0);
        chk({tag, "_ovf"},    overflow,     0);
        chk({tag, "_unf"},    underflow,    0);
        chk({tag, "_unread"}, unread_count, 0);
        chk({tag, "_held"},   held_count,   0);
    endtask

    logic [WIDTH-1:0] seq [4];

    initial begin
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
        rst = 1'b1; clear = 1'b0; rewind = 1'b0; commit = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_outputs("reset");

        // Fill to full, then overflow.
        for (int i = 0; i < 4; i++) cyc(1'b1, seq[i], 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_af", almost_full, 1);
        chk("fill_held", held_count, 4);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_wr_ptr", dut.wr_ptr, 4);

        // Read all four with idle gaps; valid must be a single-cycle pulse.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("read_data", dout, seq[i]);
            chk("read_valid", dout_valid, 1);
            idle();
            chk("valid_drop", dout_valid, 0);
        end
        chk("drained_empty", empty, 1);
        chk("drained_full", full, 1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("unf_set", underflow, 1);

        // Rewind (rd_en ignored), then partial read, rewind, full replay.
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rewind_no_valid", dout_valid, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rewind_unread", unread_count, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("replay_data", dout, seq[i]);
        end

        // Rewind, read 2, then read+commit: three released.
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("commit_held", held_count, 1);
        chk("commit_full", full, 0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_held", held_count, 4);
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_rejected_ptr", dut.wr_ptr, 7);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Rewind and commit together: commit ignored.
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rew_com_held", held_count, 4);
        chk("rew_com_unread", unread_count, 4);

        // Clear with wr_en/rd_en high.
        cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clear_held", held_count, 0);
        chk("clear_unread", unread_count, 0);
        chk("clear_ovf", overflow, 0);
        chk("clear_unf", underflow, 0);

        // Async reset between edges mid-stream.
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        wr_en = 1'b0; rd_en = 1'b0;
        #3 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        #1 rst = 1'b0;
        cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", dout, 3);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data2", dout, 2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 127) == 0));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
